// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions vs S-level interrupts, drains the pipe, pulses trap_set, redirects fetch.
// Optional drain watchdog enabled by defining TRAP_DRAIN_WDOG_EN.
module trap_ctrl #(
   parameter logic [31:0] M_TRAP_VEC    = 32'h0000_0100,
   parameter int          DRAIN_TIMEOUT = 16,
   parameter int          CNT_W         = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  cur_priv,
   input  logic        exc_valid,
   input  logic [4:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic [31:0] irq_pc,
   input  logic        irq_ext,
   input  logic        irq_timer,
   input  logic [31:0] sstatus,
   input  logic [31:0] sie,
   input  logic [31:0] sip,
   input  logic [31:0] stvec,
   input  logic        pipe_drained,
   output logic        flush_req,
   output logic        trap_busy,
   output logic        trap_set,
   output logic        trap_is_irq,
   output logic [4:0]  trap_scause,
   output logic [31:0] trap_sepc,
   output logic [31:0] trap_stval,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [31:0] redirect_pc,
   output logic        wdog_fired
);

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_e;

   state_e      state_q;
   logic        flush_q, busy_q, set_q, rvalid_q;
   logic        is_irq_q;
   logic [4:0]  cause_q;
   logic [31:0] epc_q, tval_q, vec_q, rpc_q;

   logic        glob_en, sei, ssi, sti, irq_take, wdog_hit;
   logic [4:0]  irq_cause;
   logic [31:0] vec_sel;

   assign glob_en  = (cur_priv == 2'b00) | ((cur_priv == 2'b01) & sstatus[1]);
   assign sei      = (irq_ext | sip[9]) & sie[9];
   assign ssi      = sip[1] & sie[1];
   assign sti      = (irq_timer | sip[5]) & sie[5];
   assign irq_take = glob_en & (sei | ssi | sti);
   assign irq_cause = sei ? 5'd9 : (ssi ? 5'd1 : 5'd5);
   assign vec_sel  = (cur_priv == 2'b11) ? M_TRAP_VEC : {stvec[31:2], 2'b00};

   logic unused_bits;
   assign unused_bits = ^{sstatus[31:2], sstatus[0], sie[31:10], sie[8:6], sie[4:2], sie[0],
                          sip[31:10], sip[8:6], sip[4:2], sip[0], stvec[1:0]};

`ifdef TRAP_DRAIN_WDOG_EN
   logic [CNT_W-1:0] wdog_cnt_q;
   logic             wdog_fired_q;

   // Counter reaching DRAIN_TIMEOUT this edge; a simultaneous pipe_drained takes the normal path.
   assign wdog_hit   = (state_q == DRAIN) && !pipe_drained &&
                       (wdog_cnt_q == CNT_W'(DRAIN_TIMEOUT - 1));
   assign wdog_fired = wdog_fired_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wdog_cnt_q   <= '0;
         wdog_fired_q <= 1'b0;
      end else begin
         wdog_fired_q <= wdog_hit;
         if (state_q != DRAIN)
            wdog_cnt_q <= '0;
         else if (!pipe_drained)
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end
   end
`else
   assign wdog_hit   = 1'b0;
   assign wdog_fired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         flush_q  <= 1'b0;
         busy_q   <= 1'b0;
         set_q    <= 1'b0;
         rvalid_q <= 1'b0;
         is_irq_q <= 1'b0;
         cause_q  <= '0;
         epc_q    <= '0;
         tval_q   <= '0;
         vec_q    <= '0;
         rpc_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (exc_valid || irq_take) begin
                  state_q  <= DRAIN;
                  flush_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  is_irq_q <= !exc_valid;
                  cause_q  <= exc_valid ? exc_cause : irq_cause;
                  epc_q    <= exc_valid ? exc_pc : irq_pc;
                  tval_q   <= exc_valid ? exc_tval : 32'h0;
                  vec_q    <= vec_sel;
               end
            end
            DRAIN: begin
               if (pipe_drained || wdog_hit) begin
                  state_q <= COMMIT;
                  set_q   <= 1'b1;
               end
            end
            COMMIT: begin
               state_q  <= REDIRECT;
               set_q    <= 1'b0;
               flush_q  <= 1'b0;
               rvalid_q <= 1'b1;
               rpc_q    <= vec_q;
            end
            REDIRECT: begin
               // Payload is cleared on the way out so IDLE always shows zeros.
               if (redirect_ready) begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  rvalid_q <= 1'b0;
                  rpc_q    <= '0;
                  is_irq_q <= 1'b0;
                  cause_q  <= '0;
                  epc_q    <= '0;
                  tval_q   <= '0;
                  vec_q    <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign flush_req      = flush_q;
   assign trap_busy      = busy_q;
   assign trap_set       = set_q;
   assign redirect_valid = rvalid_q;
   assign redirect_pc    = rpc_q;
   assign trap_is_irq    = is_irq_q;
   assign trap_scause    = cause_q;
   assign trap_sepc      = epc_q;
   assign trap_stval     = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table for single traps plus hand sequences for busy, stall, reset and watchdog.
module tb_trap_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  cur_priv;
   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic [31:0] exc_pc, exc_tval, irq_pc;
   logic        irq_ext, irq_timer;
   logic [31:0] sstatus, sie, sip, stvec;
   logic        pipe_drained;
   logic        flush_req, trap_busy, trap_set, trap_is_irq;
   logic [4:0]  trap_scause;
   logic [31:0] trap_sepc, trap_stval;
   logic        redirect_valid, redirect_ready;
   logic [31:0] redirect_pc;
   logic        wdog_fired;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   trap_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cur_priv(cur_priv),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .irq_pc(irq_pc), .irq_ext(irq_ext), .irq_timer(irq_timer),
      .sstatus(sstatus), .sie(sie), .sip(sip), .stvec(stvec),
      .pipe_drained(pipe_drained), .flush_req(flush_req), .trap_busy(trap_busy),
      .trap_set(trap_set), .trap_is_irq(trap_is_irq), .trap_scause(trap_scause),
      .trap_sepc(trap_sepc), .trap_stval(trap_stval),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc), .wdog_fired(wdog_fired)
   );

   typedef struct {
      logic [1:0]  priv;
      logic        exc;
      logic [4:0]  cause;
      logic [31:0] pc, tval, ipc;
      logic        ext, tmr;
      logic [31:0] sst, sie_v, sip_v, stv;
      logic        exp_trap, exp_irq;
      logic [4:0]  exp_cause;
      logic [31:0] exp_sepc, exp_stval, exp_rpc;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; irq_pc = 0;
      irq_ext = 0; irq_timer = 0; sstatus = 0; sie = 0; sip = 0;
      pipe_drained = 1; redirect_ready = 1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".flush"}, {31'b0, flush_req}, 0);
      chk({tag, ".busy"}, {31'b0, trap_busy}, 0);
      chk({tag, ".set"}, {31'b0, trap_set}, 0);
      chk({tag, ".irq"}, {31'b0, trap_is_irq}, 0);
      chk({tag, ".cause"}, {27'b0, trap_scause}, 0);
      chk({tag, ".sepc"}, trap_sepc, 0);
      chk({tag, ".stval"}, trap_stval, 0);
      chk({tag, ".rvalid"}, {31'b0, redirect_valid}, 0);
      chk({tag, ".rpc"}, redirect_pc, 0);
      chk({tag, ".wdog"}, {31'b0, wdog_fired}, 0);
   endtask

   task automatic chk_payload(input string tag, input vec_t v);
      chk({tag, ".irq"}, {31'b0, trap_is_irq}, {31'b0, v.exp_irq});
      chk({tag, ".cause"}, {27'b0, trap_scause}, {27'b0, v.exp_cause});
      chk({tag, ".sepc"}, trap_sepc, v.exp_sepc);
      chk({tag, ".stval"}, trap_stval, v.exp_stval);
   endtask

   // cur_priv is only changed by this bench while IDLE; flag any drift during a trap.
   logic [1:0] priv_prev;
   always @(posedge clk) begin
      if (rst_n && trap_busy && !redirect_valid && cur_priv !== priv_prev) begin
         n_bad++;
         $display("FAIL priv_stable: got %0d expected %0d", cur_priv, priv_prev);
      end
      priv_prev <= cur_priv;
   end

   initial begin
      // priv exc cause pc tval irq_pc ext tmr sstatus sie sip stvec | trap irq cause sepc stval rpc
      vecs[0] = '{2'b01, 1, 5'd2, 32'h1000, 32'hDEAD, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h8000_0203,
                  1, 0, 5'd2, 32'h1000, 32'hDEAD, 32'h8000_0200};
      vecs[1] = '{2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h2000, 1, 1, 32'h0, 32'h222, 32'h2, 32'h0000_4001,
                  1, 1, 5'd9, 32'h2000, 32'h0, 32'h0000_4000};
      vecs[2] = '{2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h2004, 0, 1, 32'h0, 32'h222, 32'h2, 32'h0000_4001,
                  1, 1, 5'd1, 32'h2004, 32'h0, 32'h0000_4000};
      vecs[3] = '{2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h2008, 0, 1, 32'h0, 32'h222, 32'h0, 32'h0000_5000,
                  1, 1, 5'd5, 32'h2008, 32'h0, 32'h0000_5000};
      vecs[4] = '{2'b01, 0, 5'd0, 32'h0, 32'h0, 32'h3000, 0, 1, 32'h0, 32'h20, 32'h0, 32'h0000_5000,
                  0, 0, 5'd0, 32'h0, 32'h0, 32'h0};
      vecs[5] = '{2'b11, 0, 5'd0, 32'h0, 32'h0, 32'h3000, 1, 1, 32'h2, 32'h222, 32'h222, 32'h0000_5000,
                  0, 0, 5'd0, 32'h0, 32'h0, 32'h0};
      vecs[6] = '{2'b11, 1, 5'd7, 32'h3000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0000_5000,
                  1, 0, 5'd7, 32'h3000, 32'h0, 32'h0000_0100};
      vecs[7] = '{2'b01, 1, 5'd13, 32'h4000, 32'h44, 32'h4444, 1, 0, 32'h2, 32'h200, 32'h0, 32'h0000_6002,
                  1, 0, 5'd13, 32'h4000, 32'h44, 32'h0000_6000};
      vecs[8] = '{2'b01, 0, 5'd0, 32'h0, 32'h0, 32'h5000, 0, 0, 32'h2, 32'h200, 32'h200, 32'h0000_7000,
                  1, 1, 5'd9, 32'h5000, 32'h0, 32'h0000_7000};

      cur_priv = 2'b01; stvec = 32'h0;
      idle_inputs();
      rst_n = 0;
      exc_valid = 1; exc_cause = 5'd3;
      repeat (3) tick();
      chk_all_zero("reset");
      @(negedge clk);
      exc_valid = 0; exc_cause = 0;
      rst_n = 1;
      tick();
      $display("reset: state checked");

      // Table-driven single traps
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         cur_priv = vecs[i].priv; exc_valid = vecs[i].exc; exc_cause = vecs[i].cause;
         exc_pc = vecs[i].pc; exc_tval = vecs[i].tval; irq_pc = vecs[i].ipc;
         irq_ext = vecs[i].ext; irq_timer = vecs[i].tmr; sstatus = vecs[i].sst;
         sie = vecs[i].sie_v; sip = vecs[i].sip_v; stvec = vecs[i].stv;
         tick();
         if (vecs[i].exp_trap) begin
            idle_inputs();
            chk($sformatf("v%0d.drain_busy", i), {31'b0, trap_busy}, 1);
            chk($sformatf("v%0d.drain_flush", i), {31'b0, flush_req}, 1);
            chk($sformatf("v%0d.drain_set", i), {31'b0, trap_set}, 0);
            chk_payload($sformatf("v%0d.drain", i), vecs[i]);
            tick();
            chk($sformatf("v%0d.commit_set", i), {31'b0, trap_set}, 1);
            chk($sformatf("v%0d.commit_flush", i), {31'b0, flush_req}, 1);
            chk_payload($sformatf("v%0d.commit", i), vecs[i]);
            tick();
            chk($sformatf("v%0d.redir_set", i), {31'b0, trap_set}, 0);
            chk($sformatf("v%0d.redir_flush", i), {31'b0, flush_req}, 0);
            chk($sformatf("v%0d.redir_valid", i), {31'b0, redirect_valid}, 1);
            chk($sformatf("v%0d.redir_pc", i), redirect_pc, vecs[i].exp_rpc);
            chk_payload($sformatf("v%0d.redir", i), vecs[i]);
            tick();
            chk_all_zero($sformatf("v%0d.idle", i));
         end else begin
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("v%0d.nobusy%0d", i, k), {31'b0, trap_busy}, 0);
               chk($sformatf("v%0d.noset%0d", i, k), {31'b0, trap_set}, 0);
               tick();
            end
            idle_inputs();
         end
         $display("vector %0d: priv=%0d exc=%0b expect_trap=%0b cause=%0d", i, vecs[i].priv,
                  vecs[i].exc, vecs[i].exp_trap, vecs[i].exp_cause);
      end

      // Second exception during DRAIN is ignored; exactly one trap_set
      begin
         int sets = 0;
         @(negedge clk);
         cur_priv = 2'b01; stvec = 32'h0000_9000;
         exc_valid = 1; exc_cause = 5'd4; exc_pc = 32'hA000; exc_tval = 32'h11;
         pipe_drained = 0;
         tick();
         exc_cause = 5'd6; exc_pc = 32'hB000; exc_tval = 32'h22;
         repeat (3) begin
            sets += int'(trap_set);
            tick();
         end
         pipe_drained = 1;
         for (int k = 0; k < 8; k++) begin
            sets += int'(trap_set);
            if (trap_set) begin
               chk("busy_ign.cause", {27'b0, trap_scause}, 32'd4);
               chk("busy_ign.sepc", trap_sepc, 32'hA000);
            end
            if (k == 0) exc_valid = 0;
            tick();
         end
         chk("busy_ign.set_count", sets, 1);
         idle_inputs();
         $display("busy ignore: trap_set pulses=%0d", sets);
      end

      // redirect_ready held low for 5 cycles
      begin
         @(negedge clk);
         cur_priv = 2'b01; stvec = 32'h0000_C000;
         exc_valid = 1; exc_cause = 5'd12; exc_pc = 32'hC0DE; exc_tval = 32'h77;
         redirect_ready = 0;
         tick();
         exc_valid = 0;
         tick();
         chk("stall.commit", {31'b0, trap_set}, 1);
         for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("stall.valid%0d", k), {31'b0, redirect_valid}, 1);
            chk($sformatf("stall.pc%0d", k), redirect_pc, 32'h0000_C000);
            chk($sformatf("stall.cause%0d", k), {27'b0, trap_scause}, 32'd12);
            chk($sformatf("stall.sepc%0d", k), trap_sepc, 32'hC0DE);
            chk($sformatf("stall.set%0d", k), {31'b0, trap_set}, 0);
         end
         redirect_ready = 1;
         tick();
         chk("stall.idle_busy", {31'b0, trap_busy}, 0);
         chk("stall.idle_valid", {31'b0, redirect_valid}, 0);
         idle_inputs();
         $display("handshake stall: 5 cycles held then released");
      end

      // Reset in DRAIN abandons the trap
      begin
         int sets = 0;
         @(negedge clk);
         cur_priv = 2'b01;
         exc_valid = 1; exc_cause = 5'd8; exc_pc = 32'hD000;
         pipe_drained = 0;
         tick();
         exc_valid = 0;
         chk("rst_drain.busy", {31'b0, trap_busy}, 1);
         @(negedge clk);
         rst_n = 0;
         tick();
         chk_all_zero("rst_drain");
         @(negedge clk);
         rst_n = 1;
         pipe_drained = 1;
         for (int k = 0; k < 4; k++) begin
            tick();
            sets += int'(trap_set);
         end
         chk("rst_drain.no_set", sets, 0);
         idle_inputs();
         $display("reset in DRAIN: trap abandoned");
      end

      // Pipe never drains
      begin
         @(negedge clk);
         cur_priv = 2'b01; stvec = 32'h0000_E000;
         exc_valid = 1; exc_cause = 5'd15; exc_pc = 32'hE0E0;
         pipe_drained = 0;
         tick();
         exc_valid = 0;
`ifdef TRAP_DRAIN_WDOG_EN
         for (int k = 1; k < 16; k++) begin
            tick();
            chk($sformatf("wdog.wait_set%0d", k), {31'b0, trap_set}, 0);
            chk($sformatf("wdog.wait_fire%0d", k), {31'b0, wdog_fired}, 0);
         end
         tick();
         chk("wdog.set", {31'b0, trap_set}, 1);
         chk("wdog.fired", {31'b0, wdog_fired}, 1);
         tick();
         chk("wdog.fired_pulse", {31'b0, wdog_fired}, 0);
         chk("wdog.redir", {31'b0, redirect_valid}, 1);
         $display("watchdog: forced commit after 16 DRAIN cycles");
`else
         for (int k = 1; k < 21; k++) begin
            tick();
            chk($sformatf("nowdog.flush%0d", k), {31'b0, flush_req}, 1);
            chk($sformatf("nowdog.set%0d", k), {31'b0, trap_set}, 0);
            chk($sformatf("nowdog.fire%0d", k), {31'b0, wdog_fired}, 0);
         end
         pipe_drained = 1;
         tick();
         chk("nowdog.late_set", {31'b0, trap_set}, 1);
         $display("no watchdog: DRAIN held 20 cycles, then drained");
`endif
         idle_inputs();
         repeat (3) tick();
         chk("final.idle", {31'b0, trap_busy}, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
